// File: rtl/minmax_frame_tracker_if.sv
// Sample-in / result-out handshake bundle for minmax_frame_tracker.
// The producer/consumer side uses the master modport; the tracker uses slave.
interface minmax_frame_tracker_if #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [WIDTH-1:0] out_min;
   logic [IDX_W-1:0] out_max_idx;
   logic [IDX_W-1:0] out_min_idx;
   logic             out_flat;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx, out_flat
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx, out_flat
   );
endinterface

// File: rtl/minmax_frame_tracker.sv
// Per-frame running max/min tracker. Groups FRAME_LEN unsigned samples into a
// frame, records the extremes and the index of their first occurrence, and
// offers one result record per frame. One bubble cycle separates frames.
module minmax_frame_tracker #(
   parameter int WIDTH     = 16,
   parameter int FRAME_LEN = 8,
   parameter int IDX_W     = 3
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   clear,
   minmax_frame_tracker_if.slave  bus
);
   typedef enum logic [1:0] {FIRST, ACCUM, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
   logic [IDX_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
   logic             flat_q, flat_d;
   logic             in_ready_q, out_valid_q;
   logic             load_out;
   logic             accept;

   logic [WIDTH-1:0] out_max_q, out_min_q;
   logic [IDX_W-1:0] out_max_idx_q, out_min_idx_q;
   logic             out_flat_q;

   // Unsigned magnitude comparisons of the incoming sample against the held extremes.
   logic smp_gt_max, smp_lt_min, smp_eq_max;
   assign smp_gt_max = bus.in_data >  max_q;
   assign smp_lt_min = bus.in_data <  min_q;
   assign smp_eq_max = bus.in_data == max_q;

   assign accept = bus.in_valid && in_ready_q;

   // Next-state and running extreme update.
   always_comb begin
      // NOTE: every signal gets a default here so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      max_d     = max_q;
      min_d     = min_q;
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;
      flat_d    = flat_q;
      load_out  = 1'b0;
      case (state_q)
         FIRST: begin
            if (clear) begin
               cnt_d = '0;
            end else if (accept) begin
               max_d     = bus.in_data;
               min_d     = bus.in_data;
               max_idx_d = '0;
               min_idx_d = '0;
               flat_d    = 1'b1;
               cnt_d     = IDX_W'(1);
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            if (clear) begin
               cnt_d   = '0;
               state_d = FIRST;
            end else if (accept) begin
               // Strict compares: ties keep the earliest index.
               if (smp_gt_max) begin
                  max_d     = bus.in_data;
                  max_idx_d = cnt_q;
               end
               if (smp_lt_min) begin
                  min_d     = bus.in_data;
                  min_idx_d = cnt_q;
               end
               if (!smp_eq_max) flat_d = 1'b0;
               if (cnt_q == LAST_IDX) begin
                  state_d  = DONE;
                  load_out = 1'b1;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            // clear is deliberately ignored: the pending result must be consumed.
            if (out_valid_q && bus.out_ready) begin
               cnt_d   = '0;
               state_d = FIRST;
            end
         end
         default: state_d = FIRST;
      endcase
   end

   // State, counters, running extremes and registered handshake flags.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q     <= FIRST;
         cnt_q       <= '0;
         max_q       <= '0;
         min_q       <= '0;
         max_idx_q   <= '0;
         min_idx_q   <= '0;
         flat_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         max_q       <= max_d;
         min_q       <= min_d;
         max_idx_q   <= max_idx_d;
         min_idx_q   <= min_idx_d;
         flat_q      <= flat_d;
         in_ready_q  <= (state_d != DONE);
         out_valid_q <= (state_d == DONE);
      end
   end

   // Result record, captured on entry to DONE and held until the next frame completes.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         out_max_q     <= '0;
         out_min_q     <= '0;
         out_max_idx_q <= '0;
         out_min_idx_q <= '0;
         out_flat_q    <= 1'b0;
      end else if (load_out) begin
         out_max_q     <= max_d;
         out_min_q     <= min_d;
         out_max_idx_q <= max_idx_d;
         out_min_idx_q <= min_idx_d;
         out_flat_q    <= flat_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_max     = out_max_q;
   assign bus.out_min     = out_min_q;
   assign bus.out_max_idx = out_max_idx_q;
   assign bus.out_min_idx = out_min_idx_q;
   assign bus.out_flat    = out_flat_q;
endmodule

// File: doc/minmax_frame_tracker.md
Name: minmax_frame_tracker

Overview:
- Streaming stage directly downstream of the 16-bit unsigned magnitude comparator.
- Accepts a stream of unsigned samples over a valid/ready handshake and groups them into fixed-length frames.
- For each frame, tracks the running maximum and minimum and the in-frame index of each, using gt/lt/eq results from comparator instances on the held extremes.
- Presents one result record per frame over a second valid/ready handshake.

Parameters:
- WIDTH, 16, sample width in bits; unsigned magnitude, matching the comparator operand width.
- FRAME_LEN, 8, samples per frame; legal range 2..256.
- IDX_W, 3, index width; must equal ceil(log2(FRAME_LEN)).

Ports:
- clk  input  1  rising-edge clock.
- n_rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- clear  input  1  synchronous frame abort; discards the partial frame.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  sample, unsigned.
- out_valid  output  1  result record valid.
- out_ready  input  1  consumer accepts the record.
- out_max  output  WIDTH  frame maximum.
- out_min  output  WIDTH  frame minimum.
- out_max_idx  output  IDX_W  index of the first occurrence of the maximum.
- out_min_idx  output  IDX_W  index of the first occurrence of the minimum.
- out_flat  output  1  all samples in the frame were equal.

Behaviour:
- Clock and reset: one clock, clk. n_rst is synchronous and active-low; it is sampled only on the rising edge of clk and has priority over all other inputs.
- Reset values: state=FIRST, sample count=0, in_ready=1, out_valid=0. All data outputs and internal max/min/idx registers are 0; out_flat=0.
- Transfer: an input transfer occurs when in_valid && in_ready at the clock edge. An output transfer occurs when out_valid && out_ready.
- in_ready is 1 in FIRST and ACCUM and 0 in DONE; it is registered from state only and never depends combinationally on in_valid.
- State FIRST (next index 0): on an input transfer, max=min=in_data, max_idx=min_idx=0, flat=1, count=1, go to ACCUM.
- State ACCUM:
  - On an input transfer, compare in_data against the held max and the held min.
  - If in_data gt max: max=in_data, max_idx=count.
  - If in_data lt min: min=in_data, min_idx=count.
  - If in_data is not eq max: flat=0.
  - Ties never update an index, so the earliest occurrence wins.
  - count increments.
  - When the transfer is sample FRAME_LEN-1, go to DONE.
- State DONE:
  - out_valid=1 and the out_* registers hold the frame result, stable while out_valid=1 and out_ready=0.
  - On an output transfer, go to FIRST with count=0 and out_valid=0 on the next cycle.
  - There is no result/input overlap: one bubble cycle per frame.
- Latency: out_valid rises on the clock edge that accepts the last sample of the frame, so the result is visible in the cycle after that transfer. Throughput is FRAME_LEN+1 cycles per frame minimum.
- Output registers: out_max/out_min/idx/flat are registered copies loaded on entry to DONE. They hold their value after the output transfer until the next frame completes.
- in_valid low in FIRST/ACCUM: no state change.
- clear:
  - In FIRST or ACCUM: return to FIRST with count=0, accumulated values discarded, output registers untouched. If in_valid && in_ready in the same cycle, the sample is dropped and clear wins.
  - In DONE: clear is ignored; the pending result must be consumed.
- Reset mid-frame or with a result pending: the result is lost and the block returns to reset values on that edge.
- Comparisons: unsigned only (TC tied 0); 0 < 0xFFFF.
- count wraps only via the FIRST transition, never arithmetically.

Test Plan:
- Reset then frame 3,9,1,9,7,1,5,2 (back-to-back in_valid) -> out_valid one cycle after the 8th accept; max=9 idx=1, min=1 idx=2, flat=0.
- Frame of eight 0x00AA -> max=min=0x00AA, both idx=0, flat=1.
- Frame 0x0000,0xFFFF,0x8000,0x7FFF,0x0001,0xFFFE,0x0000,0xFFFF -> max=0xFFFF idx=1, min=0x0000 idx=0 (unsigned and tie handling).
- Complete a frame, hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, offered samples not consumed; raise out_ready -> FIRST next cycle, in_ready=1, next frame result correct.
- Accept 4 samples, assert clear together with a 5th valid sample -> sample dropped; the following 8 samples 10..17 yield max=17 idx=7, min=10 idx=0.
- Random in_valid gaps with n_rst pulsed low mid-frame -> all outputs return to 0 on that edge; the next full frame result matches the reference model.
